// File: rtl/alu_pipe_if.sv
// rtl/alu_pipe_if.sv - operand/result handshake and status bundle for alu_pipe
interface alu_pipe_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic [2:0]       command;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carryout;
    logic             zero;
    logic             overflow;
    logic [TAG_W-1:0] out_tag;
    logic             sticky_overflow;
    logic             clear_sticky;
    logic [CNT_W-1:0] op_count;

    modport slave (
        input  in_valid, operand_a, operand_b, command, in_tag, out_ready, clear_sticky,
        output in_ready, out_valid, result, carryout, zero, overflow, out_tag,
               sticky_overflow, op_count
    );

    modport master (
        output in_valid, operand_a, operand_b, command, in_tag, out_ready, clear_sticky,
        input  in_ready, out_valid, result, carryout, zero, overflow, out_tag,
               sticky_overflow, op_count
    );
endinterface

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - pipelined ALU with valid/ready handshake, tag pass-through and status
module alu_pipe #(
    parameter int WIDTH     = 32,
    parameter int REG_INPUT = 1,
    parameter int TAG_W     = 4,
    parameter int CNT_W     = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_pipe_if.slave   bus
);

    typedef enum logic [2:0] {
        CMD_ADD  = 3'd0,
        CMD_SUB  = 3'd1,
        CMD_XOR  = 3'd2,
        CMD_SLT  = 3'd3,
        CMD_AND  = 3'd4,
        CMD_NAND = 3'd5,
        CMD_NOR  = 3'd6,
        CMD_OR   = 3'd7
    } cmd_e;

    logic             out_stage_free;
    logic             accept;
    logic             deliver;
    logic             load_out;

    // Operands feeding the execute logic (from s1 or straight from the input side)
    logic [WIDTH-1:0] x_a;
    logic [WIDTH-1:0] x_b;
    logic [2:0]       x_cmd;
    logic [TAG_W-1:0] x_tag;

    // Execute results
    logic             b_inv;
    logic [WIDTH-1:0] b_op;
    logic [WIDTH:0]   sum;
    logic             add_ovf;
    logic [WIDTH-1:0] c_res;
    logic             c_carry;
    logic             c_ovf;

    assign out_stage_free = !bus.out_valid || bus.out_ready;
    assign accept         = bus.in_valid && bus.in_ready;
    assign deliver        = bus.out_valid && bus.out_ready;

    generate
        if (REG_INPUT != 0) begin : g_s1
            logic             s1_valid;
            logic [WIDTH-1:0] s1_a;
            logic [WIDTH-1:0] s1_b;
            logic [2:0]       s1_cmd;
            logic [TAG_W-1:0] s1_tag;

            // Operand stage: capture on accept, empty once handed to the output stage.
            // An accept in the same cycle as a hand-off simply refills the stage.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_valid <= 1'b0;
                    s1_a     <= '0;
                    s1_b     <= '0;
                    s1_cmd   <= '0;
                    s1_tag   <= '0;
                end else if (accept) begin
                    s1_valid <= 1'b1;
                    s1_a     <= bus.operand_a;
                    s1_b     <= bus.operand_b;
                    s1_cmd   <= bus.command;
                    s1_tag   <= bus.in_tag;
                end else if (load_out) begin
                    s1_valid <= 1'b0;
                end
            end

            assign bus.in_ready = !s1_valid || out_stage_free;
            assign load_out     = s1_valid && out_stage_free;
            assign x_a          = s1_a;
            assign x_b          = s1_b;
            assign x_cmd        = s1_cmd;
            assign x_tag        = s1_tag;
        end else begin : g_direct
            assign bus.in_ready = out_stage_free;
            assign load_out     = accept;
            assign x_a          = bus.operand_a;
            assign x_b          = bus.operand_b;
            assign x_cmd        = bus.command;
            assign x_tag        = bus.in_tag;
        end
    endgenerate

    // Execute: one shared adder; SUB and SLT both use A + ~B + 1
    always_comb begin
        b_inv   = (x_cmd != CMD_ADD);
        b_op    = b_inv ? ~x_b : x_b;
        sum     = {1'b0, x_a} + {1'b0, b_op} + (WIDTH+1)'(b_inv);
        add_ovf = (x_a[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != x_a[WIDTH-1]);
        c_res   = '0;
        c_carry = 1'b0;
        c_ovf   = 1'b0;
        case (x_cmd)
            CMD_ADD, CMD_SUB: begin
                c_res   = sum[WIDTH-1:0];
                c_carry = sum[WIDTH];
                c_ovf   = add_ovf;
            end
            CMD_XOR:  c_res = x_a ^ x_b;
            CMD_SLT:  c_res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
            CMD_AND:  c_res = x_a & x_b;
            CMD_NAND: c_res = ~(x_a & x_b);
            CMD_NOR:  c_res = ~(x_a | x_b);
            CMD_OR:   c_res = x_a | x_b;
        endcase
    end

    // Output stage: load new result when free, otherwise hold until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.result    <= '0;
            bus.carryout  <= 1'b0;
            bus.zero      <= 1'b0;
            bus.overflow  <= 1'b0;
            bus.out_tag   <= '0;
        end else if (load_out) begin
            bus.out_valid <= 1'b1;
            bus.result    <= c_res;
            bus.carryout  <= c_carry;
            bus.zero      <= (c_res == '0);
            bus.overflow  <= c_ovf;
            bus.out_tag   <= x_tag;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

    // Delivery status: wrapping op counter and sticky overflow (set beats clear)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.op_count        <= '0;
            bus.sticky_overflow <= 1'b0;
        end else begin
            if (deliver) begin
                bus.op_count <= bus.op_count + CNT_W'(1);
            end
            if (deliver && bus.overflow) begin
                bus.sticky_overflow <= 1'b1;
            end else if (bus.clear_sticky) begin
                bus.sticky_overflow <= 1'b0;
            end
        end
    end

endmodule
